grf_multiport: RTL and testbench
================================

Name: grf_multiport

Overview:
- Parametrised general register file for the pipelined MIPS core.
- Successor to the single-write, two-read GRF, generalised in data width, register count and read-port count.
- Adds a second write port with fixed priority, optional write-to-read bypass, and a per-register pending-write scoreboard for hazard detection.
- Adds a registered write-trace output that replaces simulation-only write printing.
- Sits between decode (reads, issue) and the MEM/WB stages (writes).

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width; register count is 2**AW.
- NRD, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only.
- CW, 2, width of each pending-write counter.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- RA  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- RD  out  NRD*DW  read data, per port.
- RBUSY  out  NRD  per read port: pending counter of RA[i] is non-zero.
- WE  in  2  write enables, ports 0 and 1.
- WA  in  2*AW  write addresses.
- WD  in  2*DW  write data.
- WPC  in  64  PC of the writing instruction, per port (trace only).
- WCLR  in  2  per port: this write retires a scoreboard entry (decrement).
- IV  in  1  issue valid: an instruction with destination IA enters the pipeline.
- IA  in  AW  issue destination register.
- ISTALL  out  1  pending counter of IA is at maximum (2**CW-1).
- TV  out  2  trace valid, per write port.
- TA  out  2*AW  trace address.
- TD  out  2*DW  trace data.
- TPC  out  64  trace PC.

Behaviour:
- Reset (Clk edge with Reset=1):
  - all registers become 0, all pending counters become 0, TV becomes 2'b00 (TA/TD/TPC become 0).
  - writes and issues presented in that cycle are discarded.
  - Reset overrides any operation in flight.
- Register 0:
  - always reads 0.
  - writes to it are ignored and produce no trace.
  - its counter stays 0; RBUSY and ISTALL for address 0 are 0.
  - IV with IA=0 is a no-op.
- Write, port k: if WE[k] and WA[k]!=0, reg[WA[k]] <= WD[k] at the Clk edge.
  - Both ports writing the same address in one cycle: port 1 wins the array.
  - Both ports still emit trace entries.
- Read: combinational, 0-cycle latency.
  - BYPASS=1, RA[i]!=0, and a write enable matches RA[i]: RD[i] is the matching WD (port 1 priority over port 0).
  - Otherwise RD[i] = reg[RA[i]].
  - BYPASS=0: a written value is visible from the cycle after the edge.
- Scoreboard: one CW-bit counter per register.
  - inc = IV && IA!=0 && !ISTALL.
  - dec = number of ports k with WE[k] && WCLR[k] && WA[k]==r (0, 1 or 2).
  - cnt[r] <= cnt[r] + inc - dec; simultaneous inc and dec cancel.
  - Decrement below 0 saturates at 0 (protocol error; no wrap).
  - Issue while ISTALL=1 is ignored; the counter does not wrap.
  - RBUSY[i] = (cnt[RA[i]]!=0), combinational, from the current counter only (no look-ahead on same-cycle inc/dec).
- Trace: registered, 1-cycle latency.
  - For each port k with WE[k] && WA[k]!=0: the cycle after the edge, TV[k]=1 and TA/TD/TPC slice k = WA/WD/WPC.
  - Otherwise TV[k]=0 and the data fields hold their previous values.

Decomposition:
- Shared package: DW/AW defaults, ZERO_REG address constant, trace record typedef {valid, addr, data, pc}, counter-max function.
- One natural sub-module: grf_scoreboard (counter array, inc/dec/saturate, RBUSY/ISTALL lookup).
- Array, bypass mux and trace registers stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all RD=0, RBUSY=0, TV=00, ISTALL=0.
- WE=01, WA0=5, WD0=32'hDEADBEEF, WPC0=32'h3000, RA0=5, BYPASS=1 -> RD0=DEADBEEF in the same cycle; next cycle TV=01, TA0=5, TPC0=3000; RD0 still DEADBEEF with WE=0.
- Same cycle WE=11, WA0=WA1=7, WD0=1, WD1=2 -> reg7 reads 2 afterwards, TV=11, TD0=1, TD1=2.
- Write WA0=0, WD0=32'hFFFFFFFF -> reg0 reads 0, TV[0]=0; IV with IA=0 -> RBUSY for address 0 stays 0.
- Issue IA=9 three times -> ISTALL=1; fourth issue ignored; one WCLR write to 9 -> count 2; an issue plus a WCLR write to 9 in the same cycle -> count stays 2.
- Mid-sequence Reset with WE=11 and IV=1 asserted -> next cycle all registers 0, counters 0, TV=00; the writes do not appear.

Source files
------------

// File: rtl/grf_multiport_pkg.sv
// Shared definitions for the multi-port general register file:
// default geometry, the hard-wired zero register, and the trace record layout.
package grf_multiport_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
    logic [31:0]       pc;
  } trace_rec_t;

  function automatic int unsigned cnt_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters: issue increments, retiring writes decrement,
// saturating at both ends so protocol errors never wrap a counter.
module grf_scoreboard
  import grf_multiport_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int NRD = 2,
  parameter int CW  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NRD*AW-1:0] RA,
  input  logic              IV,
  input  logic [AW-1:0]     IA,
  input  logic [1:0]        WE,
  input  logic [2*AW-1:0]   WA,
  input  logic [1:0]        WCLR,
  output logic [NRD-1:0]    RBUSY,
  output logic              ISTALL
);

  localparam int unsigned NREG = 2**AW;
  localparam logic [CW-1:0] CMAX = CW'(cnt_max(CW));

  logic [CW-1:0] r_cnt  [NREG];
  logic [CW-1:0] w_next [NREG];
  logic          w_inc;
  logic [CW:0]   w_up;
  logic [1:0]    w_dn;

  always_comb begin
    ISTALL = (IA != AW'(ZERO_REG)) && (r_cnt[IA] == CMAX);
    for (int unsigned i = 0; i < NRD; i++) begin
      RBUSY[i] = (r_cnt[RA[i*AW +: AW]] != '0);
    end
  end

  // Next-count is cnt + inc - dec with a floor of zero; the ceiling is
  // guaranteed by blocking issue while ISTALL is high.
  always_comb begin
    w_inc = IV && (IA != AW'(ZERO_REG)) && !ISTALL;
    w_up  = '0;
    w_dn  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      w_up = {1'b0, r_cnt[AW'(r)]} + (CW+1)'(w_inc && (IA == AW'(r)));
      w_dn = 2'(WE[0] && WCLR[0] && (WA[0 +: AW] == AW'(r)))
           + 2'(WE[1] && WCLR[1] && (WA[AW +: AW] == AW'(r)));
      if (r == ZERO_REG) begin
        w_next[AW'(r)] = '0;
      end else if ((CW+1)'(w_dn) > w_up) begin
        w_next[AW'(r)] = '0;
      end else begin
        w_next[AW'(r)] = CW'(w_up - (CW+1)'(w_dn));
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (Reset) begin
        r_cnt[AW'(r)] <= '0;
      end else begin
        r_cnt[AW'(r)] <= w_next[AW'(r)];
      end
    end
  end

endmodule

// File: rtl/grf_multiport.sv
// Multi-port general register file: two prioritised write ports, NRD combinational
// read ports with optional write bypass, pending-write scoreboard and write trace.
module grf_multiport
  import grf_multiport_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int CW     = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NRD*AW-1:0] RA,
  output logic [NRD*DW-1:0] RD,
  output logic [NRD-1:0]    RBUSY,
  input  logic [1:0]        WE,
  input  logic [2*AW-1:0]   WA,
  input  logic [2*DW-1:0]   WD,
  input  logic [63:0]       WPC,
  input  logic [1:0]        WCLR,
  input  logic              IV,
  input  logic [AW-1:0]     IA,
  output logic              ISTALL,
  output logic [1:0]        TV,
  output logic [2*AW-1:0]   TA,
  output logic [2*DW-1:0]   TD,
  output logic [63:0]       TPC
);

  localparam int unsigned NREG = 2**AW;

  logic [DW-1:0]   r_regs [NREG];
  logic [1:0]      r_tv;
  logic [2*AW-1:0] r_ta;
  logic [2*DW-1:0] r_td;
  logic [63:0]     r_tpc;
  logic [1:0]      w_wvld;
  logic [AW-1:0]   w_ra;

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      w_wvld[k] = WE[k] && (WA[k*AW +: AW] != AW'(ZERO_REG));
    end
  end

  // Port 1 is applied after port 0 so it wins same-address collisions.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        r_regs[AW'(r)] <= '0;
      end
      r_tv  <= '0;
      r_ta  <= '0;
      r_td  <= '0;
      r_tpc <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (w_wvld[k]) begin
          r_regs[WA[k*AW +: AW]] <= WD[k*DW +: DW];
          r_ta[k*AW +: AW]       <= WA[k*AW +: AW];
          r_td[k*DW +: DW]       <= WD[k*DW +: DW];
          r_tpc[k*32 +: 32]      <= WPC[k*32 +: 32];
        end
      end
      r_tv <= w_wvld;
    end
  end

  always_comb begin
    RD   = '0;
    w_ra = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_ra = RA[i*AW +: AW];
      if (w_ra != AW'(ZERO_REG)) begin
        RD[i*DW +: DW] = r_regs[w_ra];
        if (BYPASS != 0) begin
          if (w_wvld[0] && (WA[0 +: AW] == w_ra)) RD[i*DW +: DW] = WD[0 +: DW];
          if (w_wvld[1] && (WA[AW +: AW] == w_ra)) RD[i*DW +: DW] = WD[DW +: DW];
        end
      end
    end
  end

  assign TV  = r_tv;
  assign TA  = r_ta;
  assign TD  = r_td;
  assign TPC = r_tpc;

  grf_scoreboard #(
    .AW  (AW),
    .NRD (NRD),
    .CW  (CW)
  ) u_scoreboard (
    .Clk    (Clk),
    .Reset  (Reset),
    .RA     (RA),
    .IV     (IV),
    .IA     (IA),
    .WE     (WE),
    .WA     (WA),
    .WCLR   (WCLR),
    .RBUSY  (RBUSY),
    .ISTALL (ISTALL)
  );

endmodule

// File: tb/tb_grf_multiport.sv
// Bench for grf_multiport: directed scenarios then random traffic, checked
// against an array/integer reference model of the register file semantics.
module tb_grf_multiport;
  import grf_multiport_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic [1:0]  RBUSY;
  logic [1:0]  WE;
  logic [9:0]  WA;
  logic [63:0] WD;
  logic [63:0] WPC;
  logic [1:0]  WCLR;
  logic        IV;
  logic [4:0]  IA;
  logic        ISTALL;
  logic [1:0]  TV;
  logic [9:0]  TA;
  logic [63:0] TD;
  logic [63:0] TPC;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_reg [32];
  int          mdl_cnt [32];
  trace_rec_t  mdl_tr  [2];

  always #5 Clk = ~Clk;

  grf_multiport #(
    .DW     (32),
    .AW     (5),
    .NRD    (2),
    .BYPASS (1),
    .CW     (2)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .RA     (RA),
    .RD     (RD),
    .RBUSY  (RBUSY),
    .WE     (WE),
    .WA     (WA),
    .WD     (WD),
    .WPC    (WPC),
    .WCLR   (WCLR),
    .IV     (IV),
    .IA     (IA),
    .ISTALL (ISTALL),
    .TV     (TV),
    .TA     (TA),
    .TD     (TD),
    .TPC    (TPC)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int i);
    int a;
    a = int'(RA[i*5 +: 5]);
    if (a == 0) return 32'h0;
    if (WE[1] && int'(WA[9:5]) == a) return WD[63:32];
    if (WE[0] && int'(WA[4:0]) == a) return WD[31:0];
    return mdl_reg[a];
  endfunction

  task automatic idle();
    Reset = 1'b0; WE = '0; WA = '0; WD = '0; WPC = '0; WCLR = '0; IV = 1'b0; IA = '0;
  endtask

  task automatic check_comb();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd%0d_a%0d", i, RA[i*5 +: 5]), {32'h0, RD[i*32 +: 32]}, {32'h0, exp_rd(i)});
      chk($sformatf("rbusy%0d", i), {63'h0, RBUSY[i]}, {63'h0, mdl_cnt[int'(RA[i*5 +: 5])] != 0});
    end
    chk("istall", {63'h0, ISTALL}, {63'h0, (IA != 0) && (mdl_cnt[int'(IA)] == 3)});
  endtask

  task automatic check_trace();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tv%0d", k), {63'h0, TV[k]}, {63'h0, mdl_tr[k].valid});
      chk($sformatf("ta%0d", k), {59'h0, TA[k*5 +: 5]}, {59'h0, mdl_tr[k].addr});
      chk($sformatf("td%0d", k), {32'h0, TD[k*32 +: 32]}, {32'h0, mdl_tr[k].data});
      chk($sformatf("tpc%0d", k), {32'h0, TPC[k*32 +: 32]}, {32'h0, mdl_tr[k].pc});
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check trace.
  task automatic cycle();
    int          nc [32];
    logic [31:0] nr [32];
    trace_rec_t  nt [2];
    bit          inc_ok;
    int          dec, a;
    @(negedge Clk);
    check_comb();
    nr = mdl_reg;
    nt = mdl_tr;
    inc_ok = IV && (IA != 0) && (mdl_cnt[int'(IA)] < 3);
    for (int r = 0; r < 32; r++) begin
      dec = 0;
      if (WE[0] && WCLR[0] && int'(WA[4:0]) == r) dec++;
      if (WE[1] && WCLR[1] && int'(WA[9:5]) == r) dec++;
      nc[r] = mdl_cnt[r] + ((inc_ok && int'(IA) == r) ? 1 : 0) - dec;
      if (nc[r] < 0 || r == 0) nc[r] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      a = int'(WA[k*5 +: 5]);
      nt[k].valid = WE[k] && (a != 0);
      if (nt[k].valid) begin
        nr[a]      = WD[k*32 +: 32];
        nt[k].addr = WA[k*5 +: 5];
        nt[k].data = WD[k*32 +: 32];
        nt[k].pc   = WPC[k*32 +: 32];
      end
    end
    if (Reset) begin
      for (int r = 0; r < 32; r++) begin
        nr[r] = '0;
        nc[r] = 0;
      end
      nt[0] = '0;
      nt[1] = '0;
    end
    @(posedge Clk);
    #1;
    mdl_reg = nr;
    mdl_cnt = nc;
    mdl_tr  = nt;
    check_trace();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      mdl_reg[r] = '0;
      mdl_cnt[r] = 0;
    end
    mdl_tr[0] = '0;
    mdl_tr[1] = '0;

    idle();
    RA = '0;
    Reset = 1'b1;
    cycle();
    cycle();
    Reset = 1'b0;

    // Read every address after reset.
    for (int a = 0; a < 32; a += 2) begin
      RA = {5'(a + 1), 5'(a)};
      cycle();
      chk("rst_rd", RD, 64'h0);
      chk("rst_tv", {62'h0, TV}, 64'h0);
    end

    // Single write with same-cycle bypass.
    WE = 2'b01; WA = {5'd0, 5'd5}; WD = {32'h0, 32'hDEADBEEF}; WPC = {32'h0, 32'h3000};
    RA = {5'd0, 5'd5};
    @(negedge Clk);
    chk("bypass_rd0", {32'h0, RD[31:0]}, 64'hDEADBEEF);
    cycle();
    idle();
    chk("wr_tv", {62'h0, TV}, 64'h1);
    chk("wr_ta0", {59'h0, TA[4:0]}, 64'd5);
    chk("wr_tpc0", {32'h0, TPC[31:0]}, 64'h3000);
    cycle();
    chk("wr_hold", {32'h0, RD[31:0]}, 64'hDEADBEEF);

    // Dual write to the same address: port 1 wins the array.
    WE = 2'b11; WA = {5'd7, 5'd7}; WD = {32'd2, 32'd1}; WPC = {32'h4004, 32'h4000};
    RA = {5'd7, 5'd5};
    cycle();
    idle();
    chk("dual_tv", {62'h0, TV}, 64'h3);
    chk("dual_td", TD, {32'd2, 32'd1});
    cycle();
    chk("dual_rd", {32'h0, RD[63:32]}, 64'd2);

    // Register 0 writes and issues are discarded.
    WE = 2'b01; WA = '0; WD = {32'h0, 32'hFFFFFFFF}; IV = 1'b1; IA = 5'd0; RA = '0;
    cycle();
    idle();
    chk("r0_tv0", {63'h0, TV[0]}, 64'h0);
    cycle();
    chk("r0_rd", {32'h0, RD[31:0]}, 64'h0);
    chk("r0_rbusy", {63'h0, RBUSY[0]}, 64'h0);

    // Scoreboard saturation and cancel.
    RA = {5'd0, 5'd9};
    for (int n = 0; n < 3; n++) begin
      IV = 1'b1; IA = 5'd9;
      cycle();
    end
    idle(); IA = 5'd9;
    @(negedge Clk);
    chk("sb_full", {63'h0, ISTALL}, 64'h1);
    IV = 1'b1;
    cycle();
    idle(); IA = 5'd9;
    WE = 2'b01; WA = {5'd0, 5'd9}; WD = {32'h0, 32'h99}; WCLR = 2'b01;
    cycle();
    idle(); IA = 5'd9;
    @(negedge Clk);
    chk("sb_two", {63'h0, ISTALL}, 64'h0);
    IV = 1'b1; WE = 2'b01; WA = {5'd0, 5'd9}; WD = {32'h0, 32'h9A}; WCLR = 2'b01;
    cycle();
    idle(); IA = 5'd9;
    cycle();
    chk("sb_cancel", {63'h0, ISTALL}, 64'h0);
    chk("sb_busy", {63'h0, RBUSY[0]}, 64'h1);

    // Reset overrides concurrent writes and issues.
    Reset = 1'b1; WE = 2'b11; WA = {5'd3, 5'd4}; WD = {32'h33, 32'h44}; IV = 1'b1; IA = 5'd3;
    cycle();
    idle();
    chk("rst_mid_tv", {62'h0, TV}, 64'h0);
    RA = {5'd3, 5'd7};
    cycle();
    chk("rst_mid_rd", RD, 64'h0);
    RA = {5'd9, 5'd5};
    cycle();
    chk("rst_mid_rbusy", {62'h0, RBUSY}, 64'h0);

    // Random traffic on a narrow address window to force collisions and hazards.
    for (int n = 0; n < 400; n++) begin
      Reset = ($urandom_range(0, 63) == 0);
      WE    = 2'($urandom);
      WA    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      WD    = {$urandom, $urandom};
      WPC   = {$urandom, $urandom};
      WCLR  = 2'($urandom);
      IV    = 1'($urandom);
      IA    = 5'($urandom_range(0, 7));
      RA    = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
